// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the fetch PC, issues in-order
// requests to instruction memory, tags every request with its PC, and buffers
// returned instructions for the fetch/decode register. Redirects squash the
// buffered path and mark still-outstanding responses for discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_f,
    output logic [31:0] inst_f,
    output logic        valid_f
);
    localparam int            PW        = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
    localparam logic [3:0]    DEPTH_CNT = 4'(DEPTH);
    localparam logic [31:0]   NOP       = 32'h0000_0013;

    // Architectural fetch PC
    logic [31:0]   fetch_pc_reg;

    // Tag FIFO: PCs of issued requests, popped as responses return in order
    logic [31:0]   tag_mem [DEPTH];
    logic [PW-1:0] tag_wr_ptr_reg;
    logic [PW-1:0] tag_rd_ptr_reg;
    logic [2:0]    inflight_reg;

    // Instruction queue of {pc, inst}
    logic [31:0]   q_pc_mem   [DEPTH];
    logic [31:0]   q_inst_mem [DEPTH];
    logic [PW-1:0] q_wr_ptr_reg;
    logic [PW-1:0] q_rd_ptr_reg;
    logic [2:0]    occ_reg;

    // Responses still owed to a squashed path
    logic [2:0]    discard_reg;

    logic          issue;
    logic          rsp;
    logic          q_push;
    logic          q_pop;
    logic [2:0]    inflight_next;
    logic [3:0]    credit_used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Request credit comes only from registered counts; same-cycle pops or
    // responses do not free a slot until the next cycle.
    assign credit_used   = {1'b0, inflight_reg} + {1'b0, occ_reg};
    assign imem_req      = !reset && !redirect && (credit_used < DEPTH_CNT);
    assign imem_addr     = fetch_pc_reg;
    assign issue         = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol violation: ignored.
    assign rsp           = imem_rvalid && (inflight_reg != 3'd0);
    assign q_push        = rsp && !redirect && (discard_reg == 3'd0);
    assign valid_f       = (occ_reg != 3'd0);
    assign q_pop         = valid_f && !stall && !redirect;
    assign inflight_next = inflight_reg + {2'b00, issue} - {2'b00, rsp};

    assign PC_f   = valid_f ? q_pc_mem[q_rd_ptr_reg]   : 32'd0;
    assign inst_f = valid_f ? q_inst_mem[q_rd_ptr_reg] : NOP;

    // Fetch PC, tag FIFO pointers, outstanding and discard counters
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg   <= RESET_PC;
            tag_wr_ptr_reg <= '0;
            tag_rd_ptr_reg <= '0;
            inflight_reg   <= 3'd0;
            discard_reg    <= 3'd0;
        end else begin
            inflight_reg <= inflight_next;
            if (issue) begin
                tag_wr_ptr_reg <= ptr_inc(tag_wr_ptr_reg);
            end
            if (rsp) begin
                tag_rd_ptr_reg <= ptr_inc(tag_rd_ptr_reg);
            end
            if (redirect) begin
                // Everything still outstanding after this cycle's response
                // belongs to the squashed path; earlier discards are included.
                fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
                discard_reg  <= inflight_next;
            end else begin
                if (issue) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                end
                if (rsp && (discard_reg != 3'd0)) begin
                    discard_reg <= discard_reg - 3'd1;
                end
            end
        end
    end

    // Instruction queue pointers and occupancy; redirect empties the queue
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            q_wr_ptr_reg <= '0;
            q_rd_ptr_reg <= '0;
            occ_reg      <= 3'd0;
        end else begin
            if (q_push) begin
                q_wr_ptr_reg <= ptr_inc(q_wr_ptr_reg);
            end
            if (q_pop) begin
                q_rd_ptr_reg <= ptr_inc(q_rd_ptr_reg);
            end
            occ_reg <= occ_reg + {2'b00, q_push} - {2'b00, q_pop};
        end
    end

    // Storage arrays: written at the write pointer, no reset needed
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[tag_wr_ptr_reg] <= fetch_pc_reg;
        end
        if (q_push) begin
            q_pc_mem[q_wr_ptr_reg]   <= tag_mem[tag_rd_ptr_reg];
            q_inst_mem[q_wr_ptr_reg] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks plus a scoreboard. Stimulus pushes the
// expected PC stream (memory returns word = address); a negedge monitor
// compares every presented instruction and pops on each accepted one.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        stall       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'd0;
    logic [31:0] PC_f;
    logic [31:0] inst_f;
    logic        valid_f;

    int checks = 0;
    int errors = 0;
    int pops_seen = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PC_f(PC_f), .inst_f(inst_f), .valid_f(valid_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] next_exp_pc = RESET_PC;

    task automatic sb_top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_exp_pc);
            next_exp_pc = next_exp_pc + 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        next_exp_pc = {pc[31:2], 2'b00};
        sb_top_up();
    endtask

    always @(negedge clk) begin
        if (!reset && !redirect) begin
            if (valid_f) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got pc 0x%08h expected none", PC_f);
                end else begin
                    chk("sb_pc", PC_f, exp_q[0]);
                    chk("sb_inst", inst_f, exp_q[0]);
                    if (!stall) begin
                        $display("pop %0d pc=0x%08h inst=0x%08h", pops_seen, PC_f, inst_f);
                        void'(exp_q.pop_front());
                        pops_seen++;
                    end
                end
            end else begin
                chk("idle_pc", PC_f, 32'd0);
                chk("idle_inst", inst_f, 32'h0000_0013);
            end
        end
    end

    // ---------------- memory model ----------------
    typedef struct { logic [31:0] addr; int ready; } pend_t;
    pend_t       pend_q[$];
    int          cyc = 0;
    bit          mem_hold = 1'b0;
    bit          rand_gnt = 1'b0;
    bit          rand_lat = 1'b0;
    logic        hs_issue = 1'b0;
    logic        hs_rsp   = 1'b0;
    logic        hs_reset = 1'b1;
    logic [31:0] hs_addr  = 32'd0;

    always @(negedge clk) begin
        hs_issue = imem_req && imem_gnt;
        hs_addr  = imem_addr;
        hs_rsp   = imem_rvalid;
        hs_reset = reset;
    end

    always @(posedge clk) begin
        pend_t e;
        #2;
        cyc++;
        if (hs_reset) begin
            pend_q.delete();
        end else begin
            if (hs_rsp && pend_q.size() > 0) void'(pend_q.pop_front());
            if (hs_issue) begin
                e.addr  = hs_addr;
                e.ready = cyc + (rand_lat ? int'($urandom_range(0, 3)) : 0);
                pend_q.push_back(e);
            end
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        if (!mem_hold && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_q[0].addr;
        end
        imem_gnt = rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        sb_top_up();
    endtask

    task automatic wait_drained(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = !imem_req && !valid_f;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = valid_f;
        end
        chk(name, PC_f, pc);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p0;
        bit  prev_fffc;
        bit  wrapped;

        // 1: reset state, first request, first-valid latency
        sb_restart(RESET_PC);
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", 32'(valid_f), 32'd0);
        chk("rst_pc", PC_f, 32'd0);
        chk("rst_inst", inst_f, 32'h0000_0013);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        step(); reset = 1'b0;
        @(negedge clk);
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, RESET_PC);
        step(); @(negedge clk);
        chk("t1_valid_n1", 32'(valid_f), 32'd0);
        step(); @(negedge clk);
        chk("t1_valid_n2", 32'(valid_f), 32'd1);
        chk("t1_pc_n2", PC_f, RESET_PC);
        step(); @(negedge clk);
        chk("t1_pc_n3", PC_f, RESET_PC + 32'd4);
        repeat (6) step();

        // 2: stall with a full queue, then release
        stall = 1'b1;
        repeat (5) step();
        for (int i = 0; i < 5; i++) begin
            step(); @(negedge clk);
            chk("t2_req_stalled", 32'(imem_req), 32'd0);
            chk("t2_valid_stalled", 32'(valid_f), 32'd1);
        end
        step(); stall = 1'b0;
        @(negedge clk);
        chk("t2_rel_req", 32'(imem_req), 32'd0);
        chk("t2_rel_valid", 32'(valid_f), 32'd1);
        step(); @(negedge clk);
        chk("t2_rel2_valid", 32'(valid_f), 32'd1);
        chk("t2_rel2_req", 32'(imem_req), 32'd1);
        repeat (4) step();

        // 3: redirect to an unaligned target with two requests in flight
        mem_hold = 1'b1;
        wait_drained("t3_setup");
        step(); redirect = 1'b1; redirect_pc = 32'h0100_0102; sb_restart(redirect_pc);
        @(negedge clk);
        chk("t3_req_in_redirect", 32'(imem_req), 32'd0);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("t3_addr", imem_addr, 32'h0100_0100);
        chk("t3_req_blocked", 32'(imem_req), 32'd0);
        chk("t3_valid_low", 32'(valid_f), 32'd0);
        step(); mem_hold = 1'b0;
        wait_valid("t3_first", 32'h0100_0100);
        repeat (4) step();

        // 4: redirect coincident with a response and stall
        mem_hold = 1'b1;
        wait_drained("t4_setup");
        step();
        mem_hold = 1'b0; redirect = 1'b1; stall = 1'b1;
        redirect_pc = 32'h0200_0000; sb_restart(redirect_pc);
        @(negedge clk);
        chk("t4_rvalid", 32'(imem_rvalid), 32'd1);
        chk("t4_req", 32'(imem_req), 32'd0);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("t4_empty", 32'(valid_f), 32'd0);
        chk("t4_addr", imem_addr, 32'h0200_0000);
        chk("t4_req_after", 32'(imem_req), 32'd1);
        repeat (4) step();
        wait_valid("t4_first", 32'h0200_0000);
        step(); stall = 1'b0;
        repeat (4) step();

        // 5: redirect clears a full queue
        stall = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk("t5_full_valid", 32'(valid_f), 32'd1);
        chk("t5_full_req", 32'(imem_req), 32'd0);
        step(); redirect = 1'b1; redirect_pc = 32'h0300_0010; sb_restart(redirect_pc);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("t5_cleared", 32'(valid_f), 32'd0);
        chk("t5_addr", imem_addr, 32'h0300_0010);
        wait_valid("t5_first", 32'h0300_0010);
        step(); stall = 1'b0;
        repeat (4) step();

        // 6: fetch PC wraps past 0xFFFF_FFFC
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; sb_restart(redirect_pc);
        p0 = pops_seen;
        step(); redirect = 1'b0;
        prev_fffc = 1'b0;
        wrapped   = 1'b0;
        for (int i = 0; i < 20 && !wrapped; i++) begin
            @(negedge clk);
            if (prev_fffc) begin
                chk("t6_wrap_addr", imem_addr, 32'h0000_0000);
                wrapped = 1'b1;
            end
            prev_fffc = imem_req && imem_gnt && (imem_addr == 32'hFFFF_FFFC);
        end
        chk("t6_wrap_seen", 32'(wrapped), 32'd1);
        for (int i = 0; i < 40 && pops_seen < p0 + 4; i++) step();
        chk("t6_progress", 32'(pops_seen - p0 >= 4), 32'd1);

        // 7: random grant/latency, random stalls and redirects
        rand_gnt = 1'b1;
        rand_lat = 1'b1;
        p0 = pops_seen;
        for (int i = 0; i < 20000 && pops_seen < p0 + 1000; i++) begin
            step();
            redirect = 1'b0;
            stall    = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 63) == 0) begin
                redirect    = 1'b1;
                redirect_pc = {16'h0400, 16'($urandom())};
                sb_restart(redirect_pc);
            end
        end
        step(); redirect = 1'b0; stall = 1'b0;
        chk("t7_progress", 32'(pops_seen - p0 >= 1000), 32'd1);
        rand_gnt = 1'b0;
        rand_lat = 1'b0;
        repeat (8) step();

        // 8: reset in the middle of operation
        reset = 1'b1; sb_restart(RESET_PC);
        step(); @(negedge clk);
        chk("t8_valid", 32'(valid_f), 32'd0);
        chk("t8_req", 32'(imem_req), 32'd0);
        chk("t8_addr", imem_addr, RESET_PC);
        chk("t8_inst", inst_f, 32'h0000_0013);
        step(); reset = 1'b0;
        wait_valid("t8_first", RESET_PC);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
